stream_sel_mux: RTL

- Parametrised, registered, packet-aware N:1 stream selector; successor to the 31-way combinational 2-bit selector.
- Routes one of NUM_IN valid/ready input channels to a single registered output stream.
- Holds the selected channel for a whole packet, which is delimited by a last flag.
- Sits between per-channel producers and a single downstream consumer in the test-harness datapath.

---
 rtl/stream_sel_mux.sv | 97 +++++++++
 1 files changed

// File: rtl/stream_sel_mux.sv
// stream_sel_mux: registered packet-aware N:1 stream selector; STREAM_SEL_RR_EN swaps sel for a round-robin arbiter
module stream_sel_mux #(
  parameter int NUM_IN = 31,
  parameter int WIDTH  = 2,
  parameter int SEL_W  = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN-1:0]       in_last,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic                    sel_err,
  output logic [SEL_W-1:0]        cur_ch
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_n;
  logic load_ok, en, xfer, ch_valid, ch_last, sel_err_n;
  logic [SEL_W-1:0] ch;
  logic [WIDTH-1:0] ch_data;
  logic [NUM_IN-1:0] v_sh, l_sh;
`ifdef STREAM_SEL_RR_EN
  logic [SEL_W-1:0] rr_ptr, grant;
  logic any_valid;
  logic [NUM_IN-1:0] rr_sh;
  int k;
  // first valid channel scanning upward from rr_ptr, wrapping at NUM_IN
  always_comb begin
    grant = rr_ptr;
    any_valid = 1'b0;
    k = 0;
    rr_sh = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      k = int'(rr_ptr) + i;
      k = k >= NUM_IN ? k - NUM_IN : k;
      rr_sh = in_valid >> k;
      if (!any_valid && rr_sh[0]) begin
        any_valid = 1'b1;
        grant = SEL_W'(k);
      end
    end
  end
  assign en = state == LOCKED || any_valid;
  assign ch = state == LOCKED ? cur_ch : grant;
  assign sel_err_n = 1'b0;
`else
  logic sel_ok;
  assign sel_ok = {1'b0, sel} < (SEL_W+1)'(NUM_IN);
  assign en = state == LOCKED || sel_ok;
  assign ch = state == LOCKED ? cur_ch : sel;
  assign sel_err_n = state == IDLE && !sel_ok;
`endif
  assign load_ok  = !out_valid || out_ready;
  assign in_ready = (en && load_ok) ? (NUM_IN'(1) << ch) : '0;
  assign v_sh     = in_valid >> ch;
  assign l_sh     = in_last >> ch;
  assign ch_valid = v_sh[0];
  assign ch_last  = l_sh[0];
  assign ch_data  = WIDTH'(in_data >> (int'(ch) * WIDTH));
  assign xfer     = en && load_ok && ch_valid;
  always_comb begin
    state_n = state;
    if (xfer) state_n = ch_last ? IDLE : LOCKED;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      sel_err   <= 1'b0;
      cur_ch    <= '0;
`ifdef STREAM_SEL_RR_EN
      rr_ptr    <= '0;
`endif
    end else begin
      state   <= state_n;
      sel_err <= sel_err_n;
      if (xfer) begin
        out_data  <= ch_data;
        out_valid <= 1'b1;
        out_last  <= ch_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (xfer && state == IDLE && !ch_last) cur_ch <= ch;
`ifdef STREAM_SEL_RR_EN
      if (xfer && state == IDLE) rr_ptr <= grant == SEL_W'(NUM_IN-1) ? '0 : grant + 1'b1;
`endif
    end
  end
endmodule
